// File: rtl/aud_recorder_if.sv
// ---------------------------------------------------------------------------
// aud_recorder_if
// SRAM write port and recording status bundle of the audio recorder.
//   o_address  ADDR_W  SRAM write address (stable while o_wen is high)
//   o_data     DATA_W  SRAM write data    (stable while o_wen is high)
//   o_wen      1       one-cycle write strobe
//   o_rec_len  ADDR_W  samples written since the last start
//   o_full     1       last address written; cleared by the next start
//   o_busy     1       recorder is not idle
// master: the recorder (drives everything); slave: SRAM / control side.
// ---------------------------------------------------------------------------
interface aud_recorder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] o_address;
   logic [DATA_W-1:0] o_data;
   logic              o_wen;
   logic [ADDR_W-1:0] o_rec_len;
   logic              o_full;
   logic              o_busy;

   modport master (
      output o_address, o_data, o_wen, o_rec_len, o_full, o_busy
   );

   modport slave (
      input o_address, o_data, o_wen, o_rec_len, o_full, o_busy
   );
endinterface

// File: rtl/aud_recorder.sv
// ---------------------------------------------------------------------------
// aud_recorder
// Deserialises left-channel I2S samples from the codec ADC and writes them to
// SRAM at consecutive addresses starting at 0. Start/pause/stop pulses come
// from the top-level FSM; o_rec_len tells playback how many samples are valid.
//   i_clk    codec BCLK, all logic on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_lrc    ADCLRCK, low = left channel
//   i_data   ADCDAT serial bit, MSB first after a one-bit delay slot
//   i_start  pulse: new recording from idle, or resume from pause
//   i_pause  pulse: pause while recording, resume while paused
//   i_stop   pulse: end recording
//   bus      SRAM write port and status (aud_recorder_if.master)
// ---------------------------------------------------------------------------
module aud_recorder #(
   parameter int                 DATA_W   = 16,
   parameter int                 ADDR_W   = 20,
   parameter logic [ADDR_W-1:0]  ADDR_MAX = {ADDR_W{1'b1}}
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_lrc,
   input  logic           i_data,
   input  logic           i_start,
   input  logic           i_pause,
   input  logic           i_stop,
   aud_recorder_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SHIFT,
      S_WRITE,
      S_PAUSE
   } state_t;

   // Counter only needs to reach DATA_W-1: the last bit moves straight to S_WRITE.
   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state_q, state_d;
   logic              lrc_q;
   logic [DATA_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rec_len_q, rec_len_d;
   logic              full_q, full_d;
   logic              fe;

   // Left-channel frame begins when LRCK falls; this cycle is the I2S delay slot.
   assign fe = lrc_q & ~i_lrc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         lrc_q     <= 1'b0;
         sr_q      <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         rec_len_q <= '0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lrc_q     <= i_lrc;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         rec_len_q <= rec_len_d;
         full_q    <= full_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rec_len_d = rec_len_q;
      full_d    = full_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               addr_d    = '0;
               rec_len_d = '0;
               full_d    = 1'b0;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_stop) begin
               state_d = S_IDLE;
            end else if (i_pause) begin
               state_d = S_PAUSE;
            end else if (fe) begin
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // Stop or pause abandon the partial sample; sr is fully refilled next frame.
            if (i_stop) begin
               state_d = S_IDLE;
            end else if (i_pause) begin
               state_d = S_PAUSE;
            end else begin
               sr_d  = {sr_q[DATA_W-2:0], i_data};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // The strobe is committed: stop only changes where we go next, pause is ignored.
            // A recording of exactly 2^ADDR_W samples wraps o_rec_len to 0; o_full marks it.
            rec_len_d = addr_q + 1'b1;
            if (addr_q == ADDR_MAX) begin
               full_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = i_stop ? S_IDLE : S_WAIT;
            end
         end
         S_PAUSE: begin
            // Resume lands in S_WAIT so capture re-aligns on the next LRCK fall.
            if (i_stop) begin
               state_d = S_IDLE;
            end else if (i_pause || i_start) begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.o_address = addr_q;
   assign bus.o_data    = sr_q;
   assign bus.o_wen     = (state_q == S_WRITE);
   assign bus.o_rec_len = rec_len_q;
   assign bus.o_full    = full_q;
   assign bus.o_busy    = (state_q != S_IDLE);

endmodule
